// File: rtl/mu0_pkg.sv
// mu0_pkg: sequencer state encoding and MU0/ARMish opcode constants shared with the decoder
package mu0_pkg;
  typedef enum logic [2:0] {
    S_START = 3'd0,
    S_WAIT  = 3'd1,
    S_FETCH = 3'd2,
    S_EXEC1 = 3'd3,
    S_EXEC2 = 3'd4,
    S_HALT  = 3'd5
  } state_t;
  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_STA = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_JMP = 4'b0100;
  localparam logic [3:0] OP_JGE = 4'b0101;
  localparam logic [3:0] OP_JNE = 4'b0110;
  localparam logic [3:0] OP_STP = 4'b0111;
  localparam logic [3:0] OP_AND = 4'b1000;
  localparam logic [3:0] OP_ORR = 4'b1001;
  localparam logic [3:0] OP_LSL = 4'b1010;
  localparam logic [3:0] OP_ASR = 4'b1011;
  localparam logic [1:0] OP_ARM = 2'b11;
endpackage

// File: rtl/rise_detect.sv
// rise_detect: one-cycle pulse on a rising edge of a clk-synchronous level
module rise_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic rise
);
  logic d_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) d_q <= 1'b0;
    else          d_q <= d;
  assign rise = d & ~d_q;
endmodule

// File: rtl/mu0_sequencer.sv
// mu0_sequencer: FETCH/EXEC1/EXEC2 phase sequencer with IR latch, single-step and debug counters
module mu0_sequencer
  import mu0_pkg::*;
#(
  parameter int          CNT_W    = 16,
  parameter logic [15:0] IR_RESET = 16'h0000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             run,
  input  logic             step,
  input  logic             extra,
  input  logic [15:0]      ram_q,
  output logic             fetch,
  output logic             exec1,
  output logic             exec2,
  output logic [15:0]      ir,
  output logic             halted,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] cycle_cnt
);
  state_t state, state_d;
  logic   step_rise;
  rise_detect u_step (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (step),
    .rise    (step_rise)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= S_START;
    else          state <= state_d;
  // both EXEC1 and EXEC2 finish here; RUN is only consulted at this point
  logic [2:0] done_st;
  assign done_st = run ? S_FETCH : S_WAIT;
  always_comb begin
    state_d = state;
    unique case (state)
      S_START: state_d = run ? S_FETCH : S_WAIT;
      S_WAIT:  state_d = (run | step_rise) ? S_FETCH : S_WAIT;
      S_FETCH: state_d = S_EXEC1;
      S_EXEC1: state_d = (ir[15:12] == OP_STP) ? S_HALT : extra ? S_EXEC2 : state_t'(done_st);
      S_EXEC2: state_d = state_t'(done_st);
      S_HALT:  state_d = S_HALT;
      default: state_d = S_START;
    endcase
  end
  always_comb begin
    fetch  = state == S_FETCH;
    exec1  = state == S_EXEC1;
    exec2  = state == S_EXEC2;
    halted = state == S_HALT;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      ir        <= IR_RESET;
      instr_cnt <= '0;
      cycle_cnt <= '0;
    end else begin
      if (state == S_FETCH) begin
        ir        <= ram_q;
        instr_cnt <= instr_cnt + CNT_W'(1);
      end
      if (state inside {S_FETCH, S_EXEC1, S_EXEC2}) cycle_cnt <= cycle_cnt + CNT_W'(1);
    end
endmodule

// File: tb/tb_mu0_sequencer.sv
// tb_mu0_sequencer: vector-table check of phase sequencing, IR latch, stepping, halt and counter wrap
module tb_mu0_sequencer;
  logic        clk = 1'b0, reset_n = 1'b0, run = 1'b0, step = 1'b0, extra = 1'b0;
  logic [15:0] ram_q = 16'h0000;
  logic        fetch, exec1, exec2, halted, fetch4, exec14, exec24, halted4;
  logic [15:0] ir, ir4;
  logic [15:0] instr_cnt, cycle_cnt;
  logic [3:0]  instr_cnt4, cycle_cnt4;
  int          checks = 0, failures = 0;

  always #5 clk = ~clk;

  mu0_sequencer dut (
    .clk(clk), .reset_n(reset_n), .run(run), .step(step), .extra(extra), .ram_q(ram_q),
    .fetch(fetch), .exec1(exec1), .exec2(exec2), .ir(ir), .halted(halted),
    .instr_cnt(instr_cnt), .cycle_cnt(cycle_cnt)
  );

  mu0_sequencer #(.CNT_W(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .run(run), .step(step), .extra(extra), .ram_q(ram_q),
    .fetch(fetch4), .exec1(exec14), .exec2(exec24), .ir(ir4), .halted(halted4),
    .instr_cnt(instr_cnt4), .cycle_cnt(cycle_cnt4)
  );

  typedef struct {
    logic        rn, run, step, extra;
    logic [15:0] ram;
    logic [3:0]  st;
    logic [15:0] ir;
    int          ic, cc;
  } vec_t;
  vec_t tv[$];

  function automatic void add(logic rn, logic r, logic s, logic e, logic [15:0] ram,
                              logic [3:0] st, logic [15:0] irx, int ic, int cc);
    vec_t v;
    v.rn = rn; v.run = r; v.step = s; v.extra = e; v.ram = ram;
    v.st = st; v.ir = irx; v.ic = ic; v.cc = cc;
    tv.push_back(v);
  endfunction

  task automatic check(string nm, int idx, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d actual=%0h expected=%0h", nm, idx, act, exp);
    end
  endtask

  task automatic check_all(int idx, logic [3:0] st, logic [15:0] irx, int ic, int cc);
    check("strobes", idx, {28'd0, fetch, exec1, exec2, halted}, {28'd0, st});
    check("ir", idx, {16'd0, ir}, {16'd0, irx});
    check("instr_cnt", idx, {16'd0, instr_cnt}, ic & 32'hffff);
    check("cycle_cnt", idx, {16'd0, cycle_cnt}, cc & 32'hffff);
    check("strobes_w4", idx, {28'd0, fetch4, exec14, exec24, halted4}, {28'd0, st});
    check("instr_cnt_w4", idx, {28'd0, instr_cnt4}, ic & 32'hf);
    check("cycle_cnt_w4", idx, {28'd0, cycle_cnt4}, cc & 32'hf);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    // strobe code {fetch, exec1, exec2, halted}: F=8 E1=4 E2=2 H=1 idle=0
    // ADD with EXTRA, free-run, then RUN drop and single-step interplay
    add(0, 1, 0, 0, 16'h2005, 4'h0, 16'h0000, 0, 0);
    add(1, 1, 0, 0, 16'h2005, 4'h8, 16'h0000, 0, 0);
    add(1, 1, 0, 1, 16'h2005, 4'h4, 16'h2005, 1, 1);
    add(1, 1, 0, 1, 16'h2005, 4'h2, 16'h2005, 1, 2);
    add(1, 1, 0, 1, 16'h1234, 4'h8, 16'h2005, 1, 3);
    add(1, 0, 0, 0, 16'h1234, 4'h4, 16'h1234, 2, 4);
    add(1, 0, 1, 0, 16'h1234, 4'h0, 16'h1234, 2, 5);
    add(1, 0, 1, 0, 16'h1234, 4'h0, 16'h1234, 2, 5);
    add(1, 0, 0, 0, 16'h3001, 4'h0, 16'h1234, 2, 5);
    add(1, 0, 1, 1, 16'h3001, 4'h8, 16'h1234, 2, 5);
    add(1, 0, 1, 1, 16'h3001, 4'h4, 16'h3001, 3, 6);
    add(1, 1, 1, 1, 16'h3001, 4'h2, 16'h3001, 3, 7);
    add(1, 0, 1, 0, 16'h3001, 4'h0, 16'h3001, 3, 8);
    add(1, 0, 1, 0, 16'h3001, 4'h0, 16'h3001, 3, 8);
    // STP beats EXTRA, HALT ignores RUN/STEP, reset leaves HALT
    add(0, 1, 0, 0, 16'h7000, 4'h0, 16'h0000, 0, 0);
    add(1, 1, 0, 0, 16'h7000, 4'h8, 16'h0000, 0, 0);
    add(1, 1, 0, 1, 16'h7000, 4'h4, 16'h7000, 1, 1);
    add(1, 1, 0, 1, 16'h7000, 4'h1, 16'h7000, 1, 2);
    for (int i = 0; i < 20; i++)
      add(1, i[0], i[1], 1, 16'h0000, 4'h1, 16'h7000, 1, 2);
    add(0, 1, 0, 0, 16'h0000, 4'h0, 16'h0000, 0, 0);
    // STEP held high for 10 cycles runs one instruction only
    add(0, 0, 0, 0, 16'h2005, 4'h0, 16'h0000, 0, 0);
    add(1, 0, 0, 0, 16'h2005, 4'h0, 16'h0000, 0, 0);
    add(1, 0, 1, 0, 16'h2005, 4'h8, 16'h0000, 0, 0);
    add(1, 0, 1, 0, 16'h2005, 4'h4, 16'h2005, 1, 1);
    add(1, 0, 1, 0, 16'h2005, 4'h0, 16'h2005, 1, 2);
    for (int i = 0; i < 7; i++)
      add(1, 0, 1, 0, 16'h2005, 4'h0, 16'h2005, 1, 2);
    add(1, 0, 0, 0, 16'h2005, 4'h0, 16'h2005, 1, 2);
    add(1, 0, 1, 0, 16'h2005, 4'h8, 16'h2005, 1, 2);
    add(1, 0, 0, 0, 16'h2005, 4'h4, 16'h2005, 2, 3);
    add(1, 0, 0, 0, 16'h2005, 4'h0, 16'h2005, 2, 4);
    // JMP free-run, period 2; 4-bit counters wrap along the way
    add(0, 1, 0, 0, 16'h4010, 4'h0, 16'h0000, 0, 0);
    add(1, 1, 0, 0, 16'h4010, 4'h8, 16'h0000, 0, 0);
    for (int k = 1; k <= 32; k++)
      add(1, 1, 0, 0, 16'h4010, (k % 2 == 1) ? 4'h4 : 4'h8, 16'h4010, (k + 1) / 2, k);

    foreach (tv[i]) begin
      @(negedge clk);
      reset_n = tv[i].rn; run = tv[i].run; step = tv[i].step;
      extra = tv[i].extra; ram_q = tv[i].ram;
      @(posedge clk);
      #1;
      check_all(i, tv[i].st, tv[i].ir, tv[i].ic, tv[i].cc);
    end

    // after the JMP run: FETCH, ic=16, cc=32; take a 3-cycle instruction into EXEC2
    @(negedge clk); ram_q = 16'h2005; extra = 1'b0;
    @(posedge clk); #1;
    check_all(1000, 4'h4, 16'h2005, 17, 33);
    @(negedge clk); extra = 1'b1;
    @(posedge clk); #1;
    check_all(1001, 4'h2, 16'h2005, 17, 34);
    // asynchronous reset between edges clears everything without a clock edge
    #2;
    reset_n = 1'b0;
    #1;
    check_all(1002, 4'h0, 16'h0000, 0, 0);
    @(negedge clk); reset_n = 1'b1; run = 1'b0; extra = 1'b0;
    @(posedge clk); #1;
    check_all(1003, 4'h0, 16'h0000, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
